data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_resp_array.sv | 24 ++
 rtl/data_mem_responder.sv | 117 +++++++++++
 tb/tb_data_mem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM states and access checking for the data memory responder
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Out-of-range is judged on the full address so high bits never alias into the array.
    function automatic logic access_err(
        input logic        rd,
        input logic        wr,
        input logic [1:0]  size,
        input logic [31:0] addr,
        input int unsigned depth_words
    );
        logic        bad_align;
        logic [31:0] word_idx;
        unique case (size)
            SIZE_BYTE: bad_align = 1'b0;
            SIZE_HALF: bad_align = addr[0];
            SIZE_WORD: bad_align = (addr[1:0] != 2'b00);
            SIZE_RSVD: bad_align = 1'b1;
        endcase
        word_idx   = {2'b00, addr[31:2]};
        access_err = (rd && wr) || bad_align || (word_idx >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_resp_array.sv
// rtl/dmem_resp_array.sv - word storage with per-byte-lane writes and a combinational read port
module dmem_resp_array #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk_i,
    input  logic [3:0]                     we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding data memory slave with programmable wait states
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] daddr_i,
    input  logic [31:0] dwdata_i,
    input  logic [1:0]  dsize_i,
    input  logic [3:0]  dbe_i,
    input  logic        drd_i,
    input  logic        dwr_i,
    output logic [31:0] drdata_o,
    output logic        dready_o,
    output logic        derr_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    state_e      state, state_nxt;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic [3:0]  be_q;
    logic        rd_q, wr_q;
    logic [CW-1:0] cnt_q;

    logic        in_idle, req, enter_resp, err_eff;
    logic        eff_rd, eff_wr;
    logic [31:0] eff_addr, eff_wdata, arr_rdata;
    logic [1:0]  eff_size;
    logic [3:0]  eff_be, arr_we;

    assign in_idle = (state == ST_IDLE);
    assign req     = drd_i | dwr_i;

    // With no wait states RESP is entered straight from IDLE, so the live bus feeds the commit.
    assign eff_addr  = in_idle ? daddr_i  : addr_q;
    assign eff_wdata = in_idle ? dwdata_i : wdata_q;
    assign eff_size  = in_idle ? dsize_i  : size_q;
    assign eff_be    = in_idle ? dbe_i    : be_q;
    assign eff_rd    = in_idle ? drd_i    : rd_q;
    assign eff_wr    = in_idle ? dwr_i    : wr_q;

    assign err_eff    = access_err(eff_rd, eff_wr, eff_size, eff_addr, DEPTH_WORDS);
    assign enter_resp = (state_nxt == ST_RESP);
    assign arr_we     = (enter_resp && eff_wr && !err_eff) ? eff_be : 4'b0000;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (req) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (cnt_q == '0) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
        end else if (in_idle && req) begin
            addr_q  <= daddr_i;
            wdata_q <= dwdata_i;
            size_q  <= dsize_i;
            be_q    <= dbe_i;
            rd_q    <= drd_i;
            wr_q    <= dwr_i;
            cnt_q   <= CNT_LOAD;
        end else if (state == ST_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dready_o <= 1'b0;
            derr_o   <= 1'b0;
            drdata_o <= '0;
        end else begin
            dready_o <= enter_resp;
            derr_o   <= enter_resp && err_eff;
            if (enter_resp && eff_rd) begin
                drdata_o <= err_eff ? 32'h0 : arr_rdata;
            end
        end
    end

    dmem_resp_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i  (clk_i),
        .we_i   (arr_we),
        .addr_i (eff_addr[AW+1:2]),
        .wdata_i(eff_wdata),
        .rdata_o(arr_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder at zero and three wait states
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, drd0, dwr0, dready0, derr0;
    logic [31:0] daddr0, dwdata0, drdata0;
    logic [1:0]  dsize0;
    logic [3:0]  dbe0;
    logic        rst3, drd3, dwr3, dready3, derr3;
    logic [31:0] daddr3, dwdata3, drdata3;
    logic [1:0]  dsize3;
    logic [3:0]  dbe3;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .reset_i(rst0), .daddr_i(daddr0), .dwdata_i(dwdata0), .dsize_i(dsize0),
        .dbe_i(dbe0), .drd_i(drd0), .dwr_i(dwr0), .drdata_o(drdata0), .dready_o(dready0), .derr_o(derr0)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
        .clk_i(clk), .reset_i(rst3), .daddr_i(daddr3), .dwdata_i(dwdata3), .dsize_i(dsize3),
        .dbe_i(dbe3), .drd_i(drd3), .dwr_i(dwr3), .drdata_o(drdata3), .dready_o(dready3), .derr_o(derr3)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          issue;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    exp_t e0, e3;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst0) begin
            if (dready0) begin
                if (q0.size() == 0) begin
                    check32("dut0 unexpected dready", {31'b0, dready0}, 32'h0);
                end else begin
                    e0 = q0.pop_front();
                    check32("dut0 drdata", drdata0, e0.rdata);
                    check32("dut0 derr", {31'b0, derr0}, {31'b0, e0.err});
                    check32("dut0 latency", cyc - e0.issue, e0.lat);
                end
            end else begin
                check32("dut0 derr without dready", {31'b0, derr0}, 32'h0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst3) begin
            if (dready3) begin
                if (q3.size() == 0) begin
                    check32("dut3 unexpected dready", {31'b0, dready3}, 32'h0);
                end else begin
                    e3 = q3.pop_front();
                    check32("dut3 drdata", drdata3, e3.rdata);
                    check32("dut3 derr", {31'b0, derr3}, {31'b0, e3.err});
                    check32("dut3 latency", cyc - e3.issue, e3.lat);
                end
            end else begin
                check32("dut3 derr without dready", {31'b0, derr3}, 32'h0);
            end
        end
    end

    task automatic req0(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic [3:0] be,
                        input logic [31:0] exp_d, input logic exp_e);
        int n;
        @(negedge clk);
        drd0 = rd; dwr0 = wr; daddr0 = a; dwdata0 = wd; dsize0 = sz; dbe0 = be;
        q0.push_back('{exp_d, exp_e, cyc, 1});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dready0 && n < 20);
        if (!dready0) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut0 timeout: no dready for addr %08h after %0d cycles", a, n);
        end
        drd0 = 1'b0; dwr0 = 1'b0;
    endtask

    task automatic req3(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic [3:0] be,
                        input logic [31:0] exp_d, input logic exp_e, input logic tog);
        int n;
        @(negedge clk);
        drd3 = rd; dwr3 = wr; daddr3 = a; dwdata3 = wd; dsize3 = sz; dbe3 = be;
        q3.push_back('{exp_d, exp_e, cyc, 4});
        n = 0;
        do begin
            @(negedge clk);
            n++;
            // Hostile traffic while the responder is busy must have no effect.
            if (tog && !dready3) begin
                drd3 = n[0]; dwr3 = 1'b1; daddr3 = 32'h20; dwdata3 = 32'hBAD0BAD0;
                dsize3 = 2'b10; dbe3 = 4'hF;
            end
        end while (!dready3 && n < 20);
        if (!dready3) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut3 timeout: no dready for addr %08h after %0d cycles", a, n);
        end
        drd3 = 1'b0; dwr3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; drd0 = 0; dwr0 = 0; daddr0 = 0; dwdata0 = 0; dsize0 = 0; dbe0 = 0;
        rst3 = 1'b1; drd3 = 0; dwr3 = 0; daddr3 = 0; dwdata3 = 0; dsize3 = 0; dbe3 = 0;
        repeat (3) @(negedge clk);
        check32("dut0 reset dready", {31'b0, dready0}, 32'h0);
        check32("dut0 reset derr", {31'b0, derr0}, 32'h0);
        check32("dut0 reset drdata", drdata0, 32'h0);
        check32("dut3 reset dready", {31'b0, dready3}, 32'h0);
        check32("dut3 reset drdata", drdata3, 32'h0);
        rst0 = 1'b0;
        rst3 = 1'b0;

        //   rd    wr    addr          wdata         size   be       exp drdata    err
        req0(1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 2'b10, 4'b1111, 32'h00000000, 1'b0);
        req0(1'b1, 1'b0, 32'h0000_0010, 32'h0,        2'b10, 4'b0000, 32'hDEADBEEF, 1'b0);
        req0(1'b0, 1'b1, 32'h0000_0011, 32'h0000AA00, 2'b00, 4'b0010, 32'hDEADBEEF, 1'b0);
        req0(1'b1, 1'b0, 32'h0000_0010, 32'h0,        2'b10, 4'b0000, 32'hDEADAAEF, 1'b0);
        req0(1'b1, 1'b0, 32'h0000_0012, 32'h0,        2'b10, 4'b0000, 32'h00000000, 1'b1);
        req0(1'b1, 1'b0, 32'h0000_0010, 32'h0,        2'b10, 4'b0000, 32'hDEADAAEF, 1'b0);
        req0(1'b1, 1'b1, 32'h0000_0010, 32'h55555555, 2'b10, 4'b1111, 32'h00000000, 1'b1);
        req0(1'b1, 1'b0, 32'h0000_0010, 32'h0,        2'b10, 4'b0000, 32'hDEADAAEF, 1'b0);
        req0(1'b1, 1'b0, 32'h0000_0010, 32'h0,        2'b11, 4'b0000, 32'h00000000, 1'b1);
        req0(1'b0, 1'b1, 32'h0000_0013, 32'h77000000, 2'b01, 4'b1000, 32'h00000000, 1'b1);
        req0(1'b0, 1'b1, 32'h0000_0012, 32'h12340000, 2'b01, 4'b1100, 32'h00000000, 1'b0);
        req0(1'b1, 1'b0, 32'h0000_0010, 32'h0,        2'b10, 4'b0000, 32'h1234AAEF, 1'b0);
        req0(1'b1, 1'b0, 32'h0000_1000, 32'h0,        2'b10, 4'b0000, 32'h00000000, 1'b1);
        req0(1'b0, 1'b1, 32'h0000_1010, 32'hFFFFFFFF, 2'b10, 4'b1111, 32'h00000000, 1'b1);
        req0(1'b1, 1'b0, 32'h0000_0010, 32'h0,        2'b10, 4'b0000, 32'h1234AAEF, 1'b0);
        req0(1'b0, 1'b1, 32'h0000_0FFC, 32'hA5A5A5A5, 2'b10, 4'b1111, 32'h1234AAEF, 1'b0);
        req0(1'b1, 1'b0, 32'h0000_0FFC, 32'h0,        2'b10, 4'b0000, 32'hA5A5A5A5, 1'b0);
        req0(1'b0, 1'b1, 32'h0000_0010, 32'h0,        2'b10, 4'b0000, 32'hA5A5A5A5, 1'b0);
        req0(1'b1, 1'b0, 32'h0000_0011, 32'h0,        2'b00, 4'b0000, 32'h1234AAEF, 1'b0);
        req0(1'b1, 1'b0, 32'h0000_0012, 32'h0,        2'b01, 4'b0000, 32'h1234AAEF, 1'b0);

        req3(1'b0, 1'b1, 32'h0000_0020, 32'h11223344, 2'b10, 4'b1111, 32'h00000000, 1'b0, 1'b0);
        req3(1'b1, 1'b0, 32'h0000_0020, 32'h0,        2'b10, 4'b0000, 32'h11223344, 1'b0, 1'b1);

        @(negedge clk);
        drd3 = 1'b0; dwr3 = 1'b1; daddr3 = 32'h20; dwdata3 = 32'hCAFEF00D; dsize3 = 2'b10; dbe3 = 4'hF;
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        check32("dut3 abort dready", {31'b0, dready3}, 32'h0);
        check32("dut3 abort derr", {31'b0, derr3}, 32'h0);
        check32("dut3 abort drdata", drdata3, 32'h0);
        dwr3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b0;
        req3(1'b1, 1'b0, 32'h0000_0020, 32'h0,        2'b10, 4'b0000, 32'h11223344, 1'b0, 1'b0);

        repeat (6) @(negedge clk);
        check32("dut0 scoreboard drained", q0.size(), 32'h0);
        check32("dut3 scoreboard drained", q3.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
